alu_ctrl_mdu: RTL

Parametrised successor to the ALU control decoder. It registers the decoded ALU operation code behind a valid/ready handshake. It adds an iterative multiply/divide unit (MDU) with HI/LO registers for mult/multu/div/divu, plus mfhi/mflo read-out. It sits between the main control unit and the ALU/EX stage of the datapath, and stalls issue while the MDU is busy.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/mdu_iter.sv | 114 +++++++++++
 rtl/alu_ctrl_mdu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide unit.
// Holds the AluOp and funct values, the ALU operation codes and the MDU FSM state type.
package alu_pkg;

    localparam logic [2:0] ALUOP_LWSW_ADDI = 3'b000;
    localparam logic [2:0] ALUOP_BEQ       = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE     = 3'b010;
    localparam logic [2:0] ALUOP_ORI       = 3'b011;
    localparam logic [2:0] ALUOP_SLTI      = 3'b100;
    localparam logic [2:0] ALUOP_ANDI      = 3'b101;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [3:0] ALU_OP_AND   = 4'b0000;
    localparam logic [3:0] ALU_OP_OR    = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD   = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB   = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT   = 4'b0111;
    localparam logic [3:0] ALU_OP_SHIFT = 4'b1111;
    localparam logic [3:0] ALU_OP_NOR   = 4'b1100;
    localparam logic [3:0] ALU_OP_MFHI  = 4'b1000;
    localparam logic [3:0] ALU_OP_MFLO  = 4'b1001;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one bit per cycle shift-add or restoring divide on
// operand magnitudes, with sign fix-up and divide-by-zero result generation.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic               busy;
    logic               div_mode;
    logic               neg_lo;
    logic               neg_hi;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   qm;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               div_zero;
    logic               last;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   qm_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        mag_a_in = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b_in = (is_signed && b[WIDTH-1]) ? -b : b;
        div_zero = is_div && (b == '0);
        last     = busy && (cnt == CNT_W'(WIDTH - 1));
        done     = (start && div_zero) || last;
    end

    // acc holds the running high half (product) or partial remainder (divide);
    // qm holds the multiplier being shifted out, or the dividend shifting into quotient.
    always_comb begin
        sum      = {1'b0, acc} + (qm[0] ? {1'b0, mag_b} : '0);
        shifted  = {acc, qm[WIDTH-1]};
        diff     = shifted - {1'b0, mag_b};
        acc_next = '0;
        qm_next  = '0;
        if (div_mode) begin
            acc_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            qm_next  = {qm[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_next = sum[WIDTH:1];
            qm_next  = {sum[0], qm[WIDTH-1:1]};
        end
        prod     = {acc_next, qm_next};
        prod_fix = neg_lo ? -prod : prod;
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!busy) begin
            res_hi = a;
            res_lo = '1;
        end else if (div_mode) begin
            res_lo = neg_lo ? -qm_next : qm_next;
            res_hi = neg_hi ? -acc_next : acc_next;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            qm       <= '0;
            mag_b    <= '0;
        end else if (start && !div_zero) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            neg_lo   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi   <= is_signed && a[WIDTH-1];
            cnt      <= '0;
            acc      <= '0;
            qm       <= mag_a_in;
            mag_b    <= mag_b_in;
        end else if (busy) begin
            acc <= acc_next;
            qm  <= qm_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with valid/ready issue, registered op code and an attached
// iterative multiply/divide unit writing the HI/LO registers.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned OP_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [5:0]         funct_i,
    input  logic [WIDTH-1:0]   src_a_i,
    input  logic [WIDTH-1:0]   src_b_i,
    output logic [OP_W-1:0]    op_o,
    output logic               op_valid_o,
    output logic               illegal_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               done_o
);

    mdu_state_t       state;
    mdu_state_t       state_next;

    logic             accept;
    logic [OP_W-1:0]  dec_op;
    logic             dec_op_en;
    logic             dec_ill;
    logic             dec_mdu;
    logic             dec_div;
    logic             dec_signed;
    logic             mdu_start;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    assign accept    = valid_i && ready_o;
    assign mdu_start = accept && dec_mdu;

    always_comb begin
        dec_op     = '0;
        dec_op_en  = 1'b0;
        dec_ill    = 1'b0;
        dec_mdu    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        case (alu_op_i)
            ALUOP_W'(ALUOP_LWSW_ADDI): begin dec_op = OP_W'(ALU_OP_ADD); dec_op_en = 1'b1; end
            ALUOP_W'(ALUOP_BEQ):       begin dec_op = OP_W'(ALU_OP_SUB); dec_op_en = 1'b1; end
            ALUOP_W'(ALUOP_ORI):       begin dec_op = OP_W'(ALU_OP_OR);  dec_op_en = 1'b1; end
            ALUOP_W'(ALUOP_ANDI):      begin dec_op = OP_W'(ALU_OP_AND); dec_op_en = 1'b1; end
            ALUOP_W'(ALUOP_SLTI):      begin dec_op = OP_W'(ALU_OP_SLT); dec_op_en = 1'b1; end
            ALUOP_W'(ALUOP_RTYPE): begin
                dec_op_en = 1'b1;
                case (funct_i)
                    FUNCT_ADD:  dec_op = OP_W'(ALU_OP_ADD);
                    FUNCT_SUB:  dec_op = OP_W'(ALU_OP_SUB);
                    FUNCT_AND:  dec_op = OP_W'(ALU_OP_AND);
                    FUNCT_OR:   dec_op = OP_W'(ALU_OP_OR);
                    FUNCT_SLT:  dec_op = OP_W'(ALU_OP_SLT);
                    FUNCT_SLL:  dec_op = OP_W'(ALU_OP_SHIFT);
                    FUNCT_NOR:  dec_op = OP_W'(ALU_OP_NOR);
                    FUNCT_MFHI: dec_op = OP_W'(ALU_OP_MFHI);
                    FUNCT_MFLO: dec_op = OP_W'(ALU_OP_MFLO);
                    FUNCT_MULT: begin
                        dec_op_en  = 1'b0;
                        dec_mdu    = 1'b1;
                        dec_signed = 1'b1;
                    end
                    FUNCT_MULTU: begin
                        dec_op_en = 1'b0;
                        dec_mdu   = 1'b1;
                    end
                    FUNCT_DIV: begin
                        dec_op_en  = 1'b0;
                        dec_mdu    = 1'b1;
                        dec_div    = 1'b1;
                        dec_signed = 1'b1;
                    end
                    FUNCT_DIVU: begin
                        dec_op_en = 1'b0;
                        dec_mdu   = 1'b1;
                        dec_div   = 1'b1;
                    end
                    default: begin
                        dec_op_en = 1'b0;
                        dec_ill   = 1'b1;
                    end
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Divide by zero needs no iterations, so it goes straight to StDone.
    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (mdu_start) begin
                    if (dec_div && (src_b_i == '0)) begin
                        state_next = StDone;
                    end else if (dec_div) begin
                        state_next = StDiv;
                    end else begin
                        state_next = StMul;
                    end
                end
            end
            StMul, StDiv: begin
                if (mdu_done) begin
                    state_next = StDone;
                end
            end
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        ready_o = (state == StIdle);
        done_o  = (state == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_o       <= OP_W'(ALU_OP_ADD);
            op_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            op_valid_o <= accept && dec_op_en;
            illegal_o  <= accept && dec_ill;
            if (accept && dec_op_en) begin
                op_o <= dec_op;
            end
            if (mdu_done) begin
                hi_o <= mdu_hi;
                lo_o <= mdu_lo;
            end
        end
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (mdu_start),
        .is_div   (dec_div),
        .is_signed(dec_signed),
        .a        (src_a_i),
        .b        (src_b_i),
        .done     (mdu_done),
        .res_hi   (mdu_hi),
        .res_lo   (mdu_lo)
    );

endmodule
